// File: rtl/binary_gray_codec_pipe_if.sv
// Handshake/data bundle for binary_gray_codec_pipe; slave is the codec side,
// master is the upstream/downstream environment.
interface binary_gray_codec_pipe_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 16
);
  logic                   Enable_In;
  logic                   Mode_In;
  logic                   Valid_In;
  logic                   Ready_Out;
  logic [DATA_WIDTH-1:0]  Data_In;
  logic                   Valid_Out;
  logic                   Ready_In;
  logic [DATA_WIDTH-1:0]  Data_Out;
  logic                   Mode_Out;
  logic [COUNT_WIDTH-1:0] Count_Out;

  modport slave (
    input  Enable_In, Mode_In, Valid_In, Data_In, Ready_In,
    output Ready_Out, Valid_Out, Data_Out, Mode_Out, Count_Out
  );

  modport master (
    output Enable_In, Mode_In, Valid_In, Data_In, Ready_In,
    input  Ready_Out, Valid_Out, Data_Out, Mode_Out, Count_Out
  );
endinterface

// File: rtl/binary_gray_codec_pipe.sv
// Two-stage valid/ready pipeline converting binary<->Gray per word, with a
// saturating count of delivered words and a tristated output when disabled.
module binary_gray_codec_pipe #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                      Clock_In,
  input  logic                      Reset_In,
  binary_gray_codec_pipe_if.slave   bus
);

  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_mode_q,  s1_mode_d;
  logic [DATA_WIDTH-1:0]  s1_data_q,  s1_data_d;
  logic                   s2_valid_q, s2_valid_d;
  logic                   s2_mode_q,  s2_mode_d;
  logic [DATA_WIDTH-1:0]  s2_data_q,  s2_data_d;
  logic [COUNT_WIDTH-1:0] count_q,    count_d;

  logic                   s2_load;
  logic                   s1_load;
  logic                   out_xfer;
  logic [DATA_WIDTH-1:0]  conv_result;

  always_comb begin
    s2_load  = bus.Enable_In && (!s2_valid_q || bus.Ready_In);
    s1_load  = bus.Enable_In && (!s1_valid_q || s2_load);
    out_xfer = bus.Enable_In && s2_valid_q && bus.Ready_In;

    // Gray-to-binary bit i is the parity of all Gray bits at or above i.
    conv_result = '0;
    if (!s1_mode_q) begin
      conv_result = s1_data_q ^ (s1_data_q >> 1);
    end else begin
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
        conv_result[i] = ^(s1_data_q >> i);
      end
    end

    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_mode_d  = s2_mode_q;
    s2_data_d  = s2_data_q;
    count_d    = count_q;

    if (s1_load) begin
      s1_valid_d = bus.Valid_In;
      s1_mode_d  = bus.Mode_In;
      s1_data_d  = bus.Data_In;
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      s2_mode_d  = s1_mode_q;
      s2_data_d  = conv_result;
    end

    if (out_xfer && (count_q != '1)) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_mode_q  <= 1'b0;
      s2_data_q  <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_mode_q  <= s2_mode_d;
      s2_data_q  <= s2_data_d;
      count_q    <= count_d;
    end
  end

  // During a reset cycle the stages are about to be flushed, so the block
  // already advertises an empty pipeline.
  assign bus.Ready_Out = bus.Enable_In && (Reset_In || !s1_valid_q || s2_load);
  assign bus.Valid_Out = bus.Enable_In && !Reset_In && s2_valid_q;
  assign bus.Mode_Out  = bus.Enable_In && s2_mode_q;
  assign bus.Count_Out = count_q;
  assign bus.Data_Out  = bus.Enable_In ? s2_data_q : 'z;

endmodule

// File: tb/tb_binary_gray_codec_pipe.sv
// Bench for binary_gray_codec_pipe: directed scenarios plus random traffic,
// checked against a two-slot FIFO model of the pipeline.
module tb_binary_gray_codec_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst16;
  logic rst2;

  binary_gray_codec_pipe_if #(.DATA_WIDTH(16), .COUNT_WIDTH(16)) b16 ();
  binary_gray_codec_pipe_if #(.DATA_WIDTH(2),  .COUNT_WIDTH(4))  b2  ();

  binary_gray_codec_pipe #(.DATA_WIDTH(16), .COUNT_WIDTH(16)) dut16 (
    .Clock_In (clk),
    .Reset_In (rst16),
    .bus      (b16.slave)
  );

  binary_gray_codec_pipe #(.DATA_WIDTH(2), .COUNT_WIDTH(4)) dut2 (
    .Clock_In (clk),
    .Reset_In (rst2),
    .bus      (b2.slave)
  );

  typedef struct {
    logic [63:0] word;
    bit          mode;
    int unsigned edges;
  } item_t;

  item_t       q[$];
  int unsigned sel;
  int unsigned w;
  logic [63:0] cnt_m;
  logic [63:0] cnt_max;
  int unsigned checks;
  int unsigned passes;

  function automatic logic [63:0] conv(input logic [63:0] d, input bit mode,
                                       input int unsigned width);
    logic [63:0] r;
    r = '0;
    if (!mode) r = d ^ (d >> 1);
    else for (int unsigned i = 0; i < width; i++) r[i] = ^(d >> i);
    return r;
  endfunction

  function automatic logic [63:0] get_data();
    if (sel == 0) return 64'(b16.Data_Out);
    return 64'(b2.Data_Out);
  endfunction

  function automatic logic [63:0] get_count();
    if (sel == 0) return 64'(b16.Count_Out);
    return 64'(b2.Count_Out);
  endfunction

  function automatic logic [63:0] get_mode();
    if (sel == 0) return 64'(b16.Mode_Out);
    return 64'(b2.Mode_Out);
  endfunction

  function automatic logic [63:0] get_ready();
    if (sel == 0) return 64'(b16.Ready_Out);
    return 64'(b2.Ready_Out);
  endfunction

  function automatic logic [63:0] get_valid();
    if (sel == 0) return 64'(b16.Valid_Out);
    return 64'(b2.Valid_Out);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input bit en, input bit rst, input bit vin, input bit mode,
                       input logic [63:0] din, input bit rdy);
    if (sel == 0) begin
      b16.Enable_In = en; rst16 = rst; b16.Valid_In = vin;
      b16.Mode_In = mode; b16.Data_In = din[15:0]; b16.Ready_In = rdy;
    end else begin
      b2.Enable_In = en; rst2 = rst; b2.Valid_In = vin;
      b2.Mode_In = mode; b2.Data_In = din[1:0]; b2.Ready_In = rdy;
    end
  endtask

  // One clock cycle: apply inputs, check outputs against the model, then
  // advance the model across the rising edge.
  task automatic step(input bit en, input bit rst, input bit vin, input bit mode,
                      input logic [63:0] din_raw, input bit rdy, output bit acc);
    logic [63:0] mask;
    logic [63:0] din;
    logic [63:0] zexp;
    bit          exp_v;
    bit          exp_r;
    item_t       it;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    din  = din_raw & mask;
    drive(en, rst, vin, mode, din, rdy);
    #1;
    exp_v = en && !rst && (q.size() > 0) && (q[0].edges >= 1);
    exp_r = en && (rst || (q.size() < 2) || (exp_v && rdy));
    chk("ready_out", get_ready(), 64'(exp_r));
    chk("valid_out", get_valid(), 64'(exp_v));
    chk("count_out", get_count(), cnt_m);
    if (exp_v) begin
      chk("data_out", get_data(), q[0].word);
      chk("mode_out", get_mode(), 64'(q[0].mode));
    end
    if (!en) begin
      zexp = '0;
      for (int unsigned i = 0; i < w; i++) zexp[i] = 1'bz;
      chk("data_hiz", get_data(), zexp);
      chk("mode_off", get_mode(), 64'd0);
    end
    acc = vin && exp_r && !rst;
    @(posedge clk);
    if (rst) begin
      q.delete();
      cnt_m = '0;
    end else if (en) begin
      if (exp_v && rdy) begin
        void'(q.pop_front());
        if (cnt_m != cnt_max) cnt_m = cnt_m + 64'd1;
      end
      foreach (q[i]) q[i].edges++;
      if (acc) begin
        it.word  = conv(din, mode, w);
        it.mode  = mode;
        it.edges = 0;
        q.push_back(it);
      end
    end
    #1;
  endtask

  task automatic idle(input int unsigned n);
    bit a;
    for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, a);
  endtask

  task automatic random_traffic(input int unsigned n);
    bit a;
    for (int unsigned i = 0; i < n; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom), {$urandom(), $urandom()},
           $urandom_range(0, 2) != 0, a);
    end
  endtask

  initial begin
    bit          a;
    int unsigned k;
    logic [63:0] bp_words [3];
    logic [63:0] gray2 [4];
    bp_words = '{64'h1357, 64'h2468, 64'h0F0F};
    gray2    = '{64'd0, 64'd1, 64'd3, 64'd2};
    checks = 0;
    passes = 0;

    sel = 1; drive(1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
    sel = 0; drive(1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
    @(posedge clk);
    #1;
    q.delete();
    cnt_m   = '0;
    w       = 16;
    cnt_max = 64'hFFFF;

    // Reset state, then basic binary-to-Gray stream.
    step(1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, a);
    step(1'b1, 1'b0, 1'b1, 1'b0, 64'h8000, 1'b1, a);
    step(1'b1, 1'b0, 1'b1, 1'b0, 64'h00FF, 1'b1, a);
    step(1'b1, 1'b0, 1'b1, 1'b0, 64'hFFFF, 1'b1, a);
    idle(3);

    // Gray-to-binary, then alternating modes on the same word.
    step(1'b1, 1'b0, 1'b1, 1'b1, 64'hC000, 1'b1, a);
    step(1'b1, 1'b0, 1'b1, 1'b1, 64'h0080, 1'b1, a);
    step(1'b1, 1'b0, 1'b1, 1'b1, 64'h8000, 1'b1, a);
    step(1'b1, 1'b0, 1'b1, 1'b0, 64'h0003, 1'b1, a);
    step(1'b1, 1'b0, 1'b1, 1'b1, 64'h0003, 1'b1, a);
    step(1'b1, 1'b0, 1'b1, 1'b0, 64'h0003, 1'b1, a);
    idle(3);

    // Backpressure: three words offered while downstream stalls.
    step(1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, a);
    k = 0;
    for (int unsigned c = 0; c < 5; c++) begin
      step(1'b1, 1'b0, k < 3, 1'b0, bp_words[k < 3 ? k : 0], 1'b0, a);
      if (a) k++;
    end
    for (int unsigned c = 0; c < 8; c++) begin
      step(1'b1, 1'b0, k < 3, 1'b0, bp_words[k < 3 ? k : 0], 1'b1, a);
      if (a) k++;
    end
    chk("bp_count3", get_count(), 64'd3);

    // Enable low with S2 holding a word.
    step(1'b1, 1'b0, 1'b1, 1'b0, 64'h1234, 1'b0, a);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, a);
    for (int unsigned c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b1, 1'b1, 64'hBEEF, 1'b1, a);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, a);
    idle(2);

    // Reset with both stages full, then a fresh word.
    step(1'b1, 1'b0, 1'b1, 1'b1, 64'hABCD, 1'b0, a);
    step(1'b1, 1'b0, 1'b1, 1'b0, 64'h5555, 1'b0, a);
    step(1'b1, 1'b0, 1'b1, 1'b0, 64'h7777, 1'b0, a);
    step(1'b1, 1'b1, 1'b1, 1'b0, 64'h1111, 1'b1, a);
    step(1'b1, 1'b0, 1'b1, 1'b0, 64'h00F0, 1'b1, a);
    idle(3);

    random_traffic(300);

    // Narrow instance: counter saturation and exhaustive 2-bit round trip.
    sel     = 1;
    w       = 2;
    cnt_max = 64'hF;
    q.delete();
    cnt_m   = '0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, a);
    for (int unsigned c = 0; c < 22; c++) step(1'b1, 1'b0, 1'b1, 1'(c % 2), 64'(c), 1'b1, a);
    idle(2);
    chk("count_sat", get_count(), 64'hF);
    for (int unsigned v = 0; v < 4; v++) step(1'b1, 1'b0, 1'b1, 1'b0, 64'(v), 1'b1, a);
    for (int unsigned v = 0; v < 4; v++) step(1'b1, 1'b0, 1'b1, 1'b1, gray2[v], 1'b1, a);
    idle(3);
    random_traffic(200);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
